// File: rtl/display_pkg.sv
// Shared definitions for the RGB panel scanner: FSM encodings, colour bit offsets
// inside the pixel word, and the phase layout of one 6-clock pixel slot.
package display_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_LATCH = 2'd2;
  localparam state_t S_SHOW  = 2'd3;

  localparam int R_OFS = 16;
  localparam int G_OFS = 8;
  localparam int B_OFS = 0;

  typedef logic [2:0] phase_t;

  localparam int     SLOT_LEN  = 6;
  localparam phase_t SLOT_LAST = 3'(SLOT_LEN - 1);
  localparam phase_t PH_LOAD   = 3'd3;
  localparam phase_t PH_CLK_HI = 3'd4;

endpackage

// File: rtl/bcm_timer.sv
// Binary-coded-modulation display timer: loadable down-counter whose done flag marks
// the last display clock, so a load of N keeps the caller in its display state N clocks.
module bcm_timer #(
  parameter int cnt_width = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [cnt_width-1:0] load_value,
  output logic                 done
);

  logic [cnt_width-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = en && (cnt == cnt_width'(1));

endmodule

// File: rtl/display_scanner.sv
// Row / bit-plane scanner for a shift-register RGB LED panel with BCM brightness.
// state | meaning
// IDLE  | panel blanked, waiting for run
// SHIFT | 6-clock slot per column: address, load colour bit at p=3, panel_clk high p=4..5
// LATCH | one-clock latch strobe, panel_row takes the shifted row
// SHOW  | panel enabled for base<<plane clocks, then next plane / row / frame
module display_scanner
  import display_pkg::*;
#(
  parameter int rows    = 8,
  parameter int columns = 32,
  parameter int width   = 24,
  parameter int base    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  output logic [$clog2(rows)-1:0]    orow,
  output logic [$clog2(columns)-1:0] ocol,
  input  logic [width-1:0]           o,
  output logic                       panel_r,
  output logic                       panel_g,
  output logic                       panel_b,
  output logic                       panel_clk,
  output logic                       panel_lat,
  output logic                       panel_oe_n,
  output logic [$clog2(rows)-1:0]    panel_row,
  output logic                       frame_done
);

  localparam int PLANES = width / 3;
  localparam int RW     = $clog2(rows);
  localparam int CW     = $clog2(columns);
  localparam int PW     = $clog2(PLANES);
  localparam int TW     = $clog2((base << (PLANES - 1)) + 1);

  localparam logic [RW-1:0] ROW_LAST   = RW'(rows - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(columns - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(PLANES - 1);

  state_t          state;
  phase_t          phase;
  logic [PW-1:0]   plane;
  logic [TW-1:0]   show_len;
  logic            show_done;
  logic [PLANES-1:0] r_bits, g_bits, b_bits;

  assign r_bits   = o[R_OFS +: PLANES];
  assign g_bits   = o[G_OFS +: PLANES];
  assign b_bits   = o[B_OFS +: PLANES];
  assign show_len = TW'(base) << plane;

  bcm_timer #(.cnt_width(TW)) u_bcm_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (state == S_LATCH),
    .en         (state == S_SHOW),
    .load_value (show_len),
    .done       (show_done)
  );

  // orow/ocol double as the scan row/column counters, so the memory address is
  // always the position being shifted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= '0;
      plane      <= '0;
      orow       <= '0;
      ocol       <= '0;
      panel_r    <= 1'b0;
      panel_g    <= 1'b0;
      panel_b    <= 1'b0;
      panel_clk  <= 1'b0;
      panel_lat  <= 1'b0;
      panel_oe_n <= 1'b1;
      panel_row  <= '0;
      frame_done <= 1'b0;
    end else begin
      panel_lat  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          panel_clk  <= 1'b0;
          panel_oe_n <= 1'b1;
          if (run) begin
            state <= S_SHIFT;
            phase <= '0;
            plane <= '0;
            orow  <= '0;
            ocol  <= '0;
          end
        end
        S_SHIFT: begin
          if (phase == SLOT_LAST) begin
            phase     <= '0;
            panel_clk <= 1'b0;
            if (ocol == COL_LAST) begin
              state     <= S_LATCH;
              panel_lat <= 1'b1;
              panel_row <= orow;
            end else begin
              ocol <= ocol + 1'b1;
            end
          end else begin
            phase     <= phase + 3'd1;
            panel_clk <= (phase + 3'd1) >= PH_CLK_HI;
            if ((phase + 3'd1) == PH_LOAD) begin
              panel_r <= r_bits[plane];
              panel_g <= g_bits[plane];
              panel_b <= b_bits[plane];
            end
          end
        end
        S_LATCH: begin
          state      <= S_SHOW;
          panel_oe_n <= 1'b0;
          ocol       <= '0;
        end
        S_SHOW: begin
          if (show_done) begin
            panel_oe_n <= 1'b1;
            if (plane != PLANE_LAST) begin
              plane <= plane + 1'b1;
              state <= S_SHIFT;
            end else begin
              plane <= '0;
              if (orow != ROW_LAST) begin
                orow  <= orow + 1'b1;
                state <= S_SHIFT;
              end else begin
                orow       <= '0;
                frame_done <= 1'b1;
                state      <= run ? S_SHIFT : S_IDLE;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
